// File: rtl/perceptron_pkg.sv
// Shared types and constants for the perceptron operand loader.
// Opcodes live in the top two bits of a header byte.
package perceptron_pkg;

   localparam int N_TAPS_DEF = 4;

   localparam logic [1:0] OP_NOP      = 2'b00;
   localparam logic [1:0] OP_LOAD_ALL = 2'b01;
   localparam logic [1:0] OP_LOAD_X   = 2'b10;
   localparam logic [1:0] OP_BAD      = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      LOAD_W,
      LOAD_X,
      STREAM
   } state_t;

   typedef enum logic {
      SEL_W,
      SEL_X
   } rf_sel_t;

endpackage

// File: rtl/perceptron_operand_rf.sv
// X/W operand storage: one write port, one shared read index.
// Both banks clear asynchronously so a reset leaves no stale operands.
import perceptron_pkg::*;

module perceptron_operand_rf #(
   parameter int N_TAPS = N_TAPS_DEF,
   parameter int IW     = $clog2(N_TAPS) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  rf_sel_t       wr_sel,
   input  logic [IW-1:0] wr_idx,
   input  logic [7:0]    wr_data,
   input  logic [IW-1:0] rd_idx,
   output logic [7:0]    rd_x,
   output logic [7:0]    rd_w
);

   localparam int AW = $clog2(N_TAPS);

   logic [7:0] x_mem [N_TAPS];
   logic [7:0] w_mem [N_TAPS];

   logic [AW-1:0] wa;
   logic [AW-1:0] ra;

   assign wa = wr_idx[AW-1:0];
   assign ra = rd_idx[AW-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_TAPS; i++) begin
            x_mem[i] <= '0;
            w_mem[i] <= '0;
         end
      end else if (wr_en) begin
         if (wr_sel == SEL_X)
            x_mem[wa] <= wr_data;
         else
            w_mem[wa] <= wr_data;
      end
   end

   assign rd_x = x_mem[ra];
   assign rd_w = w_mem[ra];

endmodule

// File: rtl/perceptron_loader.sv
// Byte-stream loader feeding (input, weight) pairs to a MAC.
// Headers select weight+input load, input-only reload, or nop.
import perceptron_pkg::*;

module perceptron_loader #(
   parameter int N_TAPS = N_TAPS_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] x_out,
   output logic [7:0] w_out,
   output logic       pair_valid,
   input  logic       pair_ready,
   output logic       pair_last,
   output logic       busy,
   output logic       err
);

   localparam int IW = $clog2(N_TAPS) + 1;
   localparam logic [IW-1:0] LAST = IW'(N_TAPS - 1);

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          wl_q, wl_d;
   logic          err_q, err_d;
   logic          pv_q, pv_d;

   logic          byte_xfer;
   logic          pair_xfer;
   logic          rf_we;
   rf_sel_t       rf_sel;
   logic [1:0]    op;
   logic [7:0]    rd_x;
   logic [7:0]    rd_w;

   assign in_ready  = (state_q != STREAM);
   assign byte_xfer = in_valid & in_ready & ena;
   assign pair_xfer = pv_q & pair_ready & ena;
   assign op        = in_data[7:6];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         wl_q    <= 1'b0;
         err_q   <= 1'b0;
         pv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         wl_q    <= wl_d;
         err_q   <= err_d;
         pv_q    <= pv_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      wl_d    = wl_q;
      err_d   = 1'b0;
      rf_we   = 1'b0;
      rf_sel  = SEL_W;
      unique case (state_q)
         IDLE: begin
            idx_d = '0;
            if (byte_xfer) begin
               unique case (op)
                  OP_LOAD_ALL: state_d = LOAD_W;
                  OP_LOAD_X: begin
                     if (wl_q) state_d = LOAD_X;
                     else      err_d   = 1'b1;
                  end
                  OP_BAD:  err_d = 1'b1;
                  default: ;
               endcase
            end
         end
         LOAD_W: begin
            if (byte_xfer) begin
               rf_we = 1'b1;
               if (idx_q == LAST) begin
                  idx_d   = '0;
                  wl_d    = 1'b1;
                  state_d = LOAD_X;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         LOAD_X: begin
            rf_sel = SEL_X;
            if (byte_xfer) begin
               rf_we = 1'b1;
               if (idx_q == LAST) begin
                  idx_d   = '0;
                  state_d = STREAM;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         STREAM: begin
            if (pair_xfer) begin
               if (idx_q == LAST) begin
                  idx_d   = '0;
                  state_d = IDLE;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
      pv_d = (state_d == STREAM);
   end

   perceptron_operand_rf #(
      .N_TAPS (N_TAPS),
      .IW     (IW)
   ) u_rf (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (rf_we),
      .wr_sel  (rf_sel),
      .wr_idx  (idx_q),
      .wr_data (in_data),
      .rd_idx  (idx_q),
      .rd_x    (rd_x),
      .rd_w    (rd_w)
   );

   // Operands read as zero whenever no pair is on offer.
   assign x_out      = pv_q ? rd_x : 8'h00;
   assign w_out      = pv_q ? rd_w : 8'h00;
   assign pair_valid = pv_q;
   assign pair_last  = pv_q & (idx_q == LAST);
   assign busy       = (state_q != IDLE);
   assign err        = err_q;

endmodule

// File: tb/tb_perceptron_loader.sv
// Directed bench for perceptron_loader with the default four taps.
// Drives on falling edges, samples just before the next drive.
module tb_perceptron_loader;

   localparam int NT = 4;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] x_out;
   logic [7:0] w_out;
   logic       pair_valid;
   logic       pair_ready;
   logic       pair_last;
   logic       busy;
   logic       err;

   int total;
   int bad;

   logic [7:0] exp_x [NT];
   logic [7:0] exp_w [NT];

   perceptron_loader #(.N_TAPS(NT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .x_out      (x_out),
      .w_out      (w_out),
      .pair_valid (pair_valid),
      .pair_ready (pair_ready),
      .pair_last  (pair_last),
      .busy       (busy),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      chk("in_ready_load", in_ready, 1);
      in_data  = b;
      in_valid = 1'b1;
      @(posedge clk);
   endtask

   // Header plus operand bytes; updates the weight model on a full load.
   task automatic send_frame(input logic [7:0] hdr, input logic [31:0] wv,
                             input logic [31:0] xv);
      send_byte(hdr);
      if (hdr[7:6] == 2'b01)
         for (int i = 0; i < NT; i++) begin
            exp_w[i] = wv[31-8*i -: 8];
            send_byte(wv[31-8*i -: 8]);
         end
      for (int i = 0; i < NT; i++) begin
         exp_x[i] = xv[31-8*i -: 8];
         send_byte(xv[31-8*i -: 8]);
      end
   endtask

   task automatic run_stream(input bit stall);
      int  k;
      int  cyc;
      logic rdy;
      k   = 0;
      cyc = 0;
      @(negedge clk);
      in_valid = 1'b0;
      while (k < NT && cyc < 200) begin
         if (pair_valid) begin
            chk("x_out", x_out, exp_x[k]);
            chk("w_out", w_out, exp_w[k]);
            chk("pair_last", pair_last, (k == NT-1));
            chk("in_ready_stream", in_ready, 0);
         end
         rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         pair_ready = rdy;
         if (rdy && pair_valid) k++;
         @(negedge clk);
         cyc++;
      end
      pair_ready = 1'b0;
      chk("pair_count", k, NT);
      if (!stall) chk("stream_cycles", cyc, NT);
      chk("pv_after", pair_valid, 0);
      chk("busy_after", busy, 0);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_in_ready"}, in_ready, 1);
      chk({tag, "_pv"}, pair_valid, 0);
      chk({tag, "_last"}, pair_last, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_x"}, x_out, 0);
      chk({tag, "_w"}, w_out, 0);
   endtask

   task automatic pulse_reset(input string tag);
      rst_n = 1'b0;
      #1;
      check_reset_vals(tag);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk({tag, "_pv_quiet"}, pair_valid, 0);
      end
   endtask

   task automatic bad_header(input logic [7:0] hdr, input string tag);
      send_byte(hdr);
      @(negedge clk);
      in_valid = 1'b0;
      chk({tag, "_err"}, err, 1);
      chk({tag, "_busy"}, busy, 0);
      @(negedge clk);
      chk({tag, "_err_off"}, err, 0);
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      rst_n      = 1'b0;
      ena        = 1'b1;
      in_data    = 8'h00;
      in_valid   = 1'b0;
      pair_ready = 1'b0;
      #1;
      check_reset_vals("por");
      #12 rst_n = 1'b1;

      bad_header(8'h80, "ldx_no_w");
      bad_header(8'hC0, "op_bad");

      send_byte(8'h00);
      @(negedge clk);
      in_valid = 1'b0;
      chk("nop_err", err, 0);
      chk("nop_busy", busy, 0);

      in_data  = 8'h40;
      in_valid = 1'b1;
      ena      = 1'b0;
      @(negedge clk);
      chk("ena_idle_busy", busy, 0);
      in_valid = 1'b0;
      ena      = 1'b1;

      send_frame(8'h40, 32'h0409FE01, 32'h02030507);
      run_stream(0);

      send_frame(8'h80, 32'h0, 32'h01010101);
      run_stream(0);

      send_frame(8'h80, 32'h0, 32'hA05533FF);
      run_stream(1);

      send_frame(8'h40, 32'h7F80C311, 32'h10203040);
      @(negedge clk);
      in_valid   = 1'b0;
      ena        = 1'b0;
      pair_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("ena_hold_pv", pair_valid, 1);
      chk("ena_hold_x", x_out, exp_x[0]);
      chk("ena_hold_w", w_out, exp_w[0]);
      pair_ready = 1'b0;
      ena        = 1'b1;
      run_stream(0);

      send_byte(8'h40);
      for (int i = 0; i < NT; i++) send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      @(negedge clk);
      in_valid = 1'b0;
      chk("midx_busy", busy, 1);
      pulse_reset("rst_ldx");
      bad_header(8'h80, "w_cleared");

      send_frame(8'h40, 32'h01020304, 32'h05060708);
      @(negedge clk);
      in_valid   = 1'b0;
      pair_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      pair_ready = 1'b0;
      chk("mid_pv", pair_valid, 1);
      chk("mid_x", x_out, exp_x[2]);
      chk("mid_w", w_out, exp_w[2]);
      pulse_reset("rst_str");

      send_frame(8'h40, 32'hF00D0102, 32'h0A0B0C0D);
      run_stream(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/perceptron_loader.md
PERCEPTRON_LOADER -- requirements
Module: perceptron_loader

Interface
REQ-001 SHALL take parameter N_TAPS, default 4, legal range 2..8: number of input/weight pairs per neuron.
REQ-002 SHALL have port clk  in  1  single clock; all state is on its rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port ena  in  1  when low, no handshake completes and state holds.
REQ-005 SHALL have port in_data  in  8  host byte (header, weight or input).
REQ-006 SHALL have port in_valid  in  1  in_data is valid.
REQ-007 SHALL have port in_ready  out  1  loader accepts in_data this cycle.
REQ-008 SHALL have port x_out  out  8  unsigned input operand.
REQ-009 SHALL have port w_out  out  8  signed two's-complement weight operand.
REQ-010 SHALL have port pair_valid  out  1  x_out/w_out valid for the downstream MAC.
REQ-011 SHALL have port pair_ready  in  1  downstream MAC accepts the pair.
REQ-012 SHALL have port pair_last  out  1  high with pair index N_TAPS-1.
REQ-013 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-014 SHALL have port err  out  1  one-cycle pulse on a rejected header.

Function
REQ-015 SHALL define a byte transfer as in_valid & in_ready & ena on a rising edge, and a pair transfer as pair_valid & pair_ready & ena.
REQ-016 SHALL implement states IDLE, LOAD_W, LOAD_X, STREAM.
REQ-017 IDLE SHALL hold in_ready=1 and treat each accepted byte as a header, opcode = in_data[7:6].
REQ-018 Opcode 01 SHALL move to LOAD_W; opcode 10 SHALL move to LOAD_X if weights_loaded=1.
REQ-019 Opcode 00 SHALL be consumed silently and remain in IDLE.
REQ-020 Opcode 11, or opcode 10 with weights_loaded=0, SHALL pulse err for one cycle on the following edge and remain in IDLE.
REQ-021 LOAD_W SHALL store N_TAPS bytes into W[0..N_TAPS-1] in order, set weights_loaded, then enter LOAD_X.
REQ-022 LOAD_X SHALL store N_TAPS bytes into X[0..N_TAPS-1] in order, then enter STREAM.
REQ-023 in_ready SHALL be 1 in IDLE/LOAD_W/LOAD_X and 0 in STREAM.
REQ-024 STREAM SHALL present pairs (X[i],W[i]) for i=0..N_TAPS-1 on the edge after the last X byte is accepted: one-cycle latency, pair_valid registered.
REQ-025 Each pair SHALL be held stable with pair_valid=1 until transferred; the index SHALL advance only on a transfer.
REQ-026 A pair transfer with pair_last=1 SHALL return to IDLE with pair_valid=0 on the next cycle.
REQ-027 Back-to-back pair transfers SHALL sustain one pair per cycle.
REQ-028 Byte/pair index counters SHALL be ceil(log2(N_TAPS))+1 bits wide, clear on state entry, and never wrap past N_TAPS-1.
REQ-029 Weights SHALL persist across frames; opcode 10 frames SHALL reuse them.
REQ-030 With ena low, in_ready and pair_valid SHALL still reflect state, but no transfer SHALL occur.

Reset
REQ-031 Asserting rst_n low SHALL immediately force IDLE, in_ready=1, pair_valid=0, pair_last=0, busy=0, err=0, x_out=0, w_out=0, weights_loaded=0, and all X/W storage to 0.
REQ-032 Reset during any state, including mid-frame or mid-stream, SHALL abandon the frame without emitting further pairs.

Structure
REQ-033 Shared package perceptron_pkg SHALL hold N_TAPS default, opcode constants OP_NOP/OP_LOAD_ALL/OP_LOAD_X/OP_BAD, and the state enum.
REQ-034 X/W storage SHALL be a sub-module perceptron_operand_rf: write port (sel, idx, data) and one read index. All other logic stays in perceptron_loader.

Verification
REQ-035 Header 0x40, W bytes 04,09,FE,01, then X bytes 02,03,05,07, pair_ready=1 -> four pairs (02,04),(03,09),(05,FE),(07,01) on consecutive cycles, pair_last on the 4th, then IDLE.
REQ-036 After REQ-035, header 0x80 with X bytes 01,01,01,01 -> pairs reuse W 04,09,FE,01.
REQ-037 Directly after reset, header 0x80 -> err pulse of one cycle; state stays IDLE; a following 0x40 frame works normally.
REQ-038 Header 0xC0 -> err pulse; header 0x00 -> no err, no state change.
REQ-039 Random pair_ready stalls during STREAM -> every pair held stable until accepted; none lost or duplicated; in_ready=0 throughout.
REQ-040 rst_n pulsed low after 2 X bytes, or after 2 pairs -> outputs take reset values asynchronously, and no pair_valid appears until a new full frame.
